// File: rtl/floppy_pkg.sv
// Shared definitions for the floppy sector-buffer logic: default widths,
// arbiter FSM states and the side encoding used to index per-side state.
package floppy_pkg;

  localparam int AW = 9;
  localparam int DW = 8;

  localparam bit SIDE_CPU = 1'b0;
  localparam bit SIDE_FDC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sector_buf_arbiter_if.sv
// One requester's access port into the sector buffer (CPU or FDC side).
interface sector_buf_arbiter_if #(
  parameter int AW = floppy_pkg::AW,
  parameter int DW = floppy_pkg::DW
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          done;

  modport master (output req, we, addr, wdata, input rdata, done);
  modport slave  (input req, we, addr, wdata, output rdata, done);
endinterface

// File: rtl/sector_buf_arbiter_edge_strobe.sv
// Registered rising-edge detector for a clk-synchronous level such as phi_0.
module edge_strobe (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic strobe_o
);
  logic level_q;
  logic strobe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      level_q  <= level_i;
      strobe_q <= level_i & ~level_q;
    end
  end

  assign strobe_o = strobe_q;
endmodule

// File: rtl/sector_buf_arbiter.sv
// Serialises CPU and FDC accesses onto one single-port sector RAM: CPU has
// priority, but an FDC request that has waited STARVE_MAX cycles wins ties.
module sector_buf_arbiter #(
  parameter int AW         = floppy_pkg::AW,
  parameter int DW         = floppy_pkg::DW,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                phi_0_i,
  input  logic                fdc_clk_i,
  sector_buf_arbiter_if.slave cpu_if,
  sector_buf_arbiter_if.slave fdc_if,
  output logic                ram_en_o,
  output logic                ram_we_o,
  output logic [AW-1:0]       ram_addr_o,
  output logic [DW-1:0]       ram_wdata_o,
  input  logic [DW-1:0]       ram_rdata_i,
  input  logic                err_clr_i,
  output logic [1:0]          ovr_err_o
);
  import floppy_pkg::*;

  localparam int            CW      = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  // Per-side vectors, bit/element index = side encoding.
  logic [1:0]    level, strobe, req_in, we_in;
  logic [AW-1:0] addr_in  [2];
  logic [DW-1:0] wdata_in [2];

  assign level                = {fdc_clk_i, phi_0_i};
  assign req_in               = {fdc_if.req, cpu_if.req};
  assign we_in                = {fdc_if.we, cpu_if.we};
  assign addr_in[SIDE_CPU]    = cpu_if.addr;
  assign addr_in[SIDE_FDC]    = fdc_if.addr;
  assign wdata_in[SIDE_CPU]   = cpu_if.wdata;
  assign wdata_in[SIDE_FDC]   = fdc_if.wdata;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_strobe
    edge_strobe u_edge (
      .clk      (clk),
      .rst      (rst),
      .level_i  (level[gi]),
      .strobe_o (strobe[gi])
    );
  end

  state_e        state_q, state_d;
  logic [1:0]    pend_q, pend_d, lat_we_q, lat_we_d;
  logic [AW-1:0] lat_addr_q  [2];
  logic [AW-1:0] lat_addr_d  [2];
  logic [DW-1:0] lat_wdata_q [2];
  logic [DW-1:0] lat_wdata_d [2];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc_side_q, acc_side_d, acc_we_q, acc_we_d;
  logic          ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic [DW-1:0] rdata_q [2];
  logic [DW-1:0] rdata_d [2];
  logic [1:0]    done_q, done_d, ovr_q, ovr_d;
  logic          gnt_any, gnt_side;
  logic [1:0]    gnt, ovr_set;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    cnt_d       = cnt_q;
    acc_side_d  = acc_side_q;
    acc_we_d    = acc_we_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rdata_d     = rdata_q;
    done_d      = 2'b00;
    ovr_set     = 2'b00;
    gnt         = 2'b00;

    // IDLE and DONE are both arbitration points; ACC always hands over to DONE.
    gnt_any  = (state_q != ST_ACC) && (pend_q != 2'b00);
    gnt_side = (pend_q[SIDE_FDC] && (!pend_q[SIDE_CPU] || cnt_q == CNT_MAX)) ? SIDE_FDC : SIDE_CPU;
    if (gnt_any) gnt[gnt_side] = 1'b1;

    unique case (state_q)
      ST_IDLE: state_d = gnt_any ? ST_ACC : ST_IDLE;
      ST_ACC:  state_d = ST_DONE;
      ST_DONE: begin
        state_d            = gnt_any ? ST_ACC : ST_IDLE;
        done_d[acc_side_q] = 1'b1;
        if (!acc_we_q) rdata_d[acc_side_q] = ram_rdata_i;
      end
      default: state_d = ST_IDLE;
    endcase

    if (gnt_any) begin
      acc_side_d  = gnt_side;
      acc_we_d    = lat_we_q[gnt_side];
      ram_en_d    = 1'b1;
      ram_we_d    = lat_we_q[gnt_side];
      ram_addr_d  = lat_addr_q[gnt_side];
      ram_wdata_d = lat_wdata_q[gnt_side];
    end

    if (gnt[SIDE_FDC])                           cnt_d = '0;
    else if (pend_q[SIDE_FDC] && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;

    // A grant frees the slot in the same cycle, so a coincident strobe is a new request.
    pend_d = pend_q & ~gnt;
    for (int i = 0; i < 2; i++) begin
      if (strobe[i] && req_in[i]) begin
        if (pend_q[i] && !gnt[i]) begin
          ovr_set[i] = 1'b1;
        end else begin
          pend_d[i]      = 1'b1;
          lat_we_d[i]    = we_in[i];
          lat_addr_d[i]  = addr_in[i];
          lat_wdata_d[i] = wdata_in[i];
        end
      end
    end

    ovr_d = (ovr_q & ~{2{err_clr_i}}) | ovr_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      lat_we_q    <= '0;
      lat_addr_q  <= '{default: '0};
      lat_wdata_q <= '{default: '0};
      cnt_q       <= '0;
      acc_side_q  <= 1'b0;
      acc_we_q    <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '{default: '0};
      done_q      <= '0;
      ovr_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      cnt_q       <= cnt_d;
      acc_side_q  <= acc_side_d;
      acc_we_q    <= acc_we_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
    end
  end

  assign ram_en_o     = ram_en_q;
  assign ram_we_o     = ram_we_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_wdata_o  = ram_wdata_q;
  assign ovr_err_o    = ovr_q;
  assign cpu_if.rdata = rdata_q[SIDE_CPU];
  assign cpu_if.done  = done_q[SIDE_CPU];
  assign fdc_if.rdata = rdata_q[SIDE_FDC];
  assign fdc_if.done  = done_q[SIDE_FDC];
endmodule

// File: doc/sector_buf_arbiter.md
# sector_buf_arbiter

Arbitrates one single-port sector-buffer RAM between the 6502 bus side and the floppy controller (FDC) side. Requests are sampled on the rising edges of the `phi_0` and `fdc_clk` clock-gen outputs, which are synchronous to `clk`. Each sampled request is queued as one pending access per side. The block serialises pending accesses onto the RAM with CPU priority and an FDC anti-starvation override. It sits between `clock_gen`, the bus interface, the FDC datapath and the buffer BRAM.

## Interface
- `AW`, 9, RAM address width (512-byte sector)
- `DW`, 8, data width
- `STARVE_MAX`, 4, cycles an FDC pending access may lose before it wins ties
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `phi_0`  in  1  CPU phase clock from `clock_gen` (level, `clk`-synchronous)
- `fdc_clk`  in  1  FDC clock from `clock_gen` (level, `clk`-synchronous)
- `cpu_req`, `cpu_we`  in  1  CPU access request / write
- `cpu_addr`  in  AW;  `cpu_wdata`  in  DW
- `cpu_rdata`  out  DW  read data, held until the next CPU read completes
- `cpu_done`  out  1  one-cycle completion pulse
- `fdc_req`, `fdc_we`, `fdc_addr`, `fdc_wdata`, `fdc_rdata`, `fdc_done`: same as the CPU side, for the FDC
- `ram_en`, `ram_we`  out  1;  `ram_addr`  out  AW;  `ram_wdata`  out  DW
- `ram_rdata`  in  DW  valid the cycle after `ram_en`
- `err_clr`  in  1  clears `ovr_err`
- `ovr_err`  out  2  sticky overrun flags, bit 0 = CPU, bit 1 = FDC

## Operation
**Reset values.** Every output is registered. Reset value of all outputs is 0; pending flags, starvation counter and FSM state (IDLE) are also 0.

**Strobes.** `phi_0` and `fdc_clk` are registered each cycle. A strobe is asserted where the current level is 1 and the registered level is 0.

**Capture on strobe.**
- If the side's `req`=1 on its strobe, latch `we`/`addr`/`wdata` and set that side's pending flag.
- If the pending flag is already set, the new request is dropped and the side's `ovr_err` bit is set.

**FSM states:** IDLE, ACC, DONE.
- **IDLE:** if any side is pending, grant it, clear its pending flag and go to ACC.
- **ACC:** drive `ram_en`=1 with the granted side's `we`/`addr`/`wdata`, then go to DONE.
- **DONE:** register `ram_rdata` into the side's `rdata` (reads only; writes leave `rdata` unchanged) and pulse `done`. Re-arbitrate in the same cycle: go to ACC if a side is pending, otherwise go to IDLE.

**Arbitration.**
- The CPU wins simultaneous pending.
- Exception: the FDC wins if its wait counter equals `STARVE_MAX`.
- The wait counter increments every cycle the FDC is pending and not granted, saturates at `STARVE_MAX`, and clears on FDC grant. Counter width is clog2(`STARVE_MAX`+1).

**Boundary conditions.**
- A strobe during the side's own ACC/DONE is a new request, not an overrun, because the pending flag was cleared at grant.
- Strobe and grant in the same cycle for the same side: the grant consumes the old request and the new one sets pending.
- `err_clr` and an overrun in the same cycle: the set wins.
- `rst` mid-access: aborts immediately, the RAM strobe drops, no `done` is issued and pending requests are lost.

## Timing
- Strobe visible in cycle E+1 (registered edge); pending set at end of E+1.
- Uncontended path: grant in E+2, `ram_en` high in E+3, `ram_rdata` sampled in E+4, `done` pulse and `rdata` valid in E+5.
- Back-to-back accesses: one access every 2 cycles (ACC, DONE).
- Worst-case CPU wait behind one FDC access: +2 cycles.
- `done` is exactly 1 cycle wide.

## Structure
- Shared package `floppy_pkg`: `AW`/`DW` defaults, FSM state enum, side encoding constants (`SIDE_CPU`=0, `SIDE_FDC`=1).
- One sub-module, `edge_strobe`, a rising-edge detector, instantiated for `phi_0` and `fdc_clk`.

## Test plan
- **CPU write then read.** CPU write of 0x5A to address 0x1FF on a `phi_0` edge, then a CPU read of 0x1FF on the next edge -> `ram_we`=1 with address 0x1FF, then `cpu_rdata`=0x5A with `cpu_done` at E+5.
- **Simultaneous strobes.** CPU and FDC strobes in the same cycle, with the FDC counter at 0 -> `ram_en` for CPU first, FDC two cycles later, two separate `done` pulses.
- **Starvation override.** FDC held pending while CPU strobes every 2 cycles -> after 4 lost cycles the FDC is granted ahead of the pending CPU request.
- **Overrun.** Two FDC strobes with `fdc_req`=1 before a grant (CPU kept busy) -> `ovr_err`=2'b10, second request dropped, one `fdc_done`. Then `err_clr` -> `ovr_err`=0.
- **Reset mid-access.** `rst` asserted during ACC -> `ram_en`, `done` and pending flags all 0 immediately; after release no `done` appears without new strobes.
- **Gated strobe.** `req`=0 on a strobe -> no RAM access.
